// File: rtl/calc_pkg.sv
// Shared types and widths for the calculator controller and its button front end.
package calc_pkg;

  localparam int DATA_W = 32;
  localparam int SW_W   = 16;
  localparam int OP_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operand B is the switch word with its top bit copied into the upper half.
  function automatic logic [DATA_W-1:0] sextSw(input logic [SW_W-1:0] v);
    return {{(DATA_W - SW_W){v[SW_W-1]}}, v};
  endfunction

endpackage

// File: rtl/calc_debounce.sv
// Button front end: 2-FF synchronizer, counting debouncer and a one-cycle
// rising-edge pulse. A button already held when reset ends stays disarmed
// until it has been seen released once, so it cannot fire a stale press.
module calc_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam logic [7:0] CNT_MAX = 8'(DB_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       primed1_q, primed2_q, armed_q;
  logic       level_q, level_d, levelPrev_q;
  logic [7:0] cnt_q, cnt_d;

  // Bring the raw button into the clock domain and arm once a release is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      primed1_q <= 1'b0;
      primed2_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      primed1_q <= 1'b1;
      primed2_q <= primed1_q;
      armed_q   <= armed_q | (primed2_q & ~sync2_q);
    end
  end

  // Flip the debounced level only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync2_q;
      cnt_d   = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Hold the debounced level and its previous value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q     <= 1'b0;
      levelPrev_q <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      level_q     <= level_d;
      levelPrev_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  assign pulse_o = level_q & ~levelPrev_q & armed_q;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator controller: turns debounced execute/clear presses into one ALU
// operation at a time, holding operands steady while the external ALU works
// and accumulating its result. Clear always beats execute.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btnc,
  input  logic              btnac,
  input  logic [OP_W-1:0]   alu_op_in,
  input  logic [SW_W-1:0]   sw,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovf,
  output logic [SW_W-1:0]   led,
  output logic              busy,
  output logic              ovf_flag
);

  localparam logic [1:0] LAT_LOAD = 2'(ALU_LAT - 1);

  logic execPulse, clrPulse;

  state_e            state_q;
  logic [DATA_W-1:0] acc_q, opB_q;
  logic [OP_W-1:0]   op_q;
  logic [1:0]        latCnt_q;
  logic              ovf_q, busy_q;

  calc_debounce #(.DB_CYCLES(DB_CYCLES)) u_execBtn (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btnc),
    .pulse_o (execPulse)
  );

  calc_debounce #(.DB_CYCLES(DB_CYCLES)) u_clearBtn (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btnac),
    .pulse_o (clrPulse)
  );

  // Operation sequencer: latch operands, wait out the ALU latency, write back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      opB_q    <= '0;
      op_q     <= '0;
      latCnt_q <= 2'd0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (clrPulse) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      latCnt_q <= 2'd0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (execPulse) begin
            op_q     <= alu_op_in;
            opB_q    <= sextSw(sw);
            latCnt_q <= LAT_LOAD;
            state_q  <= EXEC;
            busy_q   <= 1'b1;
          end
        end
        EXEC: begin
          if (latCnt_q == 2'd0) begin
            acc_q   <= alu_result;
            ovf_q   <= ovf_q | alu_ovf;
            state_q <= DONE;
          end else begin
            latCnt_q <= latCnt_q - 2'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a    = acc_q;
  assign alu_b    = opB_q;
  assign alu_op   = op_q;
  assign led      = acc_q[SW_W-1:0];
  assign busy     = busy_q;
  assign ovf_flag = ovf_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Bench for calc_ctrl. Two controllers share the same buttons: a fast one
// (DB_CYCLES=4, ALU_LAT=1) and a slow-ALU one with a short debounce
// (DB_CYCLES=1, ALU_LAT=3) so presses can land while it is busy. Each has an
// adding ALU. A timeline model predicts every output each cycle; directed
// checks pin specific hand-computed values.
module tb_calc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btnc = 1'b0, btnac = 1'b0;
  logic [3:0]  opIn = 4'd0;
  logic [15:0] swIn = 16'd0;
  logic        forceOvf = 1'b0;

  logic [31:0] aluA [2];
  logic [31:0] aluB [2];
  logic [31:0] aluRes [2];
  logic [3:0]  aluOp [2];
  logic [15:0] led [2];
  logic        busy [2];
  logic        ovf [2];

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  assign aluRes[0] = aluA[0] + aluB[0];
  assign aluRes[1] = aluA[1] + aluB[1];

  calc_ctrl #(.DB_CYCLES(4), .ALU_LAT(1)) dutFast (
    .clk(clk), .rst(rst), .btnc(btnc), .btnac(btnac), .alu_op_in(opIn), .sw(swIn),
    .alu_a(aluA[0]), .alu_b(aluB[0]), .alu_op(aluOp[0]), .alu_result(aluRes[0]),
    .alu_ovf(forceOvf), .led(led[0]), .busy(busy[0]), .ovf_flag(ovf[0])
  );

  calc_ctrl #(.DB_CYCLES(1), .ALU_LAT(3)) dutSlow (
    .clk(clk), .rst(rst), .btnc(btnc), .btnac(btnac), .alu_op_in(opIn), .sw(swIn),
    .alu_a(aluA[1]), .alu_b(aluB[1]), .alu_op(aluOp[1]), .alu_result(aluRes[1]),
    .alu_ovf(forceOvf), .led(led[1]), .busy(busy[1]), .ovf_flag(ovf[1])
  );

  function automatic int dbOf(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int latOf(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // ---------------- behavioural model ----------------
  // Raw button samples are recorded per clock edge since reset; the debounced
  // level, arming and operation timeline are derived from that history.
  bit          rawC [0:4095];
  bit          rawA [0:4095];
  int          edgeNo = 0;
  int          firstLowC = -1, firstLowA = -1;
  logic [31:0] mAcc [2];
  logic [31:0] mB [2];
  logic [3:0]  mOp [2];
  logic        mOvf [2], mBusy [2], lvlC [2], lvlA [2], pC [2], pA [2];
  int          wEdge [2], dEdge [2];

  function automatic bit rawAt(bit isClear, int k);
    if (k < 1 || k > 4095) return 1'b0;
    return isClear ? rawA[k] : rawC[k];
  endfunction

  function automatic bit allRaw(bit isClear, int fromK, int toK, bit v);
    for (int k = fromK; k <= toK; k++)
      if (rawAt(isClear, k) != v) return 1'b0;
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      edgeNo = 0; firstLowC = -1; firstLowA = -1;
      for (int i = 0; i < 2; i++) begin
        mAcc[i] = 0; mB[i] = 0; mOp[i] = 0; mOvf[i] = 0; mBusy[i] = 0;
        lvlC[i] = 0; lvlA[i] = 0; pC[i] = 0; pA[i] = 0; wEdge[i] = 0; dEdge[i] = 0;
      end
    end else begin
      edgeNo++;
      rawC[edgeNo] = btnc;
      rawA[edgeNo] = btnac;
      if (firstLowC < 0 && !btnc)  firstLowC = edgeNo;
      if (firstLowA < 0 && !btnac) firstLowA = edgeNo;
      for (int i = 0; i < 2; i++) begin
        bit newC, newA;
        // act on presses seen during the cycle that just ended
        if (pA[i]) begin
          mAcc[i] = 0; mOvf[i] = 0; mBusy[i] = 0;
        end else if (!mBusy[i]) begin
          if (pC[i]) begin
            mOp[i]   = opIn;
            mB[i]    = {{16{swIn[15]}}, swIn};
            mBusy[i] = 1;
            wEdge[i] = edgeNo + latOf(i);
            dEdge[i] = wEdge[i] + 1;
          end
        end else if (edgeNo == wEdge[i]) begin
          mAcc[i] = mAcc[i] + mB[i];
          mOvf[i] = mOvf[i] | forceOvf;
        end else if (edgeNo == dEdge[i]) begin
          mBusy[i] = 0;
        end
        // debounced levels and presses visible in the coming cycle
        newC = lvlC[i];
        if (allRaw(1'b0, edgeNo - 1 - dbOf(i), edgeNo - 2, !lvlC[i])) newC = !lvlC[i];
        pC[i] = newC && !lvlC[i] && (firstLowC >= 1) && (firstLowC + 2 <= edgeNo);
        lvlC[i] = newC;
        newA = lvlA[i];
        if (allRaw(1'b1, edgeNo - 1 - dbOf(i), edgeNo - 2, !lvlA[i])) newA = !lvlA[i];
        pA[i] = newA && !lvlA[i] && (firstLowA >= 1) && (firstLowA + 2 <= edgeNo);
        lvlA[i] = newA;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst && edgeNo > 0) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("inst%0d_busy", i),   {31'd0, busy[i]}, {31'd0, mBusy[i]});
        checkOutput($sformatf("inst%0d_led", i),    {16'd0, led[i]},  {16'd0, mAcc[i][15:0]});
        checkOutput($sformatf("inst%0d_alu_a", i),  aluA[i],          mAcc[i]);
        checkOutput($sformatf("inst%0d_alu_b", i),  aluB[i],          mB[i]);
        checkOutput($sformatf("inst%0d_alu_op", i), {28'd0, aluOp[i]}, {28'd0, mOp[i]});
        checkOutput($sformatf("inst%0d_ovf", i),    {31'd0, ovf[i]},  {31'd0, mOvf[i]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic c, input logic ac, input logic [15:0] s, input logic [3:0] op);
    btnc = c; btnac = ac; swIn = s; opIn = op;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic printSummary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
  endtask

  int sawBusy0, sawBusy1, busyCount1;

  initial begin
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0000);
    waitEdges(3);
    $display("[TB] reset state");
    checkOutput("rst_led",  {16'd0, led[0]},  32'h0);
    checkOutput("rst_busy", {31'd0, busy[0]}, 32'h0);
    checkOutput("rst_op",   {28'd0, aluOp[0]}, 32'h0);
    checkOutput("rst_ovf",  {31'd0, ovf[0]},  32'h0);
    rst = 1'b0;
    waitEdges(5);

    $display("[TB] single op, press held 10 cycles");
    applyStimulus(1'b1, 1'b0, 16'h0005, 4'b0010);
    busyCount1 = 0;
    for (int i = 1; i <= 10; i++) begin
      waitEdges(1);
      if (busy[1]) busyCount1++;
      if (i == 6) checkOutput("busy_before_op", {31'd0, busy[0]}, 32'h0);
      if (i == 7) checkOutput("busy_exec",      {31'd0, busy[0]}, 32'h1);
      if (i == 8) begin
        checkOutput("busy_done",    {31'd0, busy[0]}, 32'h1);
        checkOutput("led_after_op", {16'd0, led[0]},  32'h5);
      end
      if (i == 9) checkOutput("busy_idle", {31'd0, busy[0]}, 32'h0);
    end
    checkOutput("slow_busy_cycles", busyCount1, 32'd4);
    applyStimulus(1'b0, 1'b0, 16'h0005, 4'b0010);
    waitEdges(12);
    checkOutput("one_op_fast", {16'd0, led[0]}, 32'h5);
    checkOutput("one_op_slow", {16'd0, led[1]}, 32'h5);

    $display("[TB] sign extension");
    applyStimulus(1'b1, 1'b0, 16'hFFFE, 4'b0010);
    for (int i = 1; i <= 10; i++) begin
      waitEdges(1);
      if (i == 7) checkOutput("sext_b", aluB[0], 32'hFFFF_FFFE);
    end
    applyStimulus(1'b0, 1'b0, 16'hFFFE, 4'b0010);
    waitEdges(12);
    checkOutput("sext_led_fast", {16'd0, led[0]}, 32'h3);
    checkOutput("sext_led_slow", {16'd0, led[1]}, 32'h3);

    $display("[TB] bounce rejection");
    sawBusy0 = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(((i / 2) % 2) == 0, 1'b0, 16'h0010, 4'b0010);
      waitEdges(1);
      if (busy[0]) sawBusy0 = 1;
    end
    checkOutput("bounce_no_op", sawBusy0, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0010, 4'b0010);
    waitEdges(12);
    applyStimulus(1'b0, 1'b0, 16'h0010, 4'b0010);
    waitEdges(12);
    checkOutput("bounce_one_op", {16'd0, led[0]}, 32'h13);

    $display("[TB] clear, then slow ALU with a press during busy and overflow");
    applyStimulus(1'b0, 1'b1, 16'h0000, 4'b0010);
    waitEdges(8);
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0010);
    waitEdges(10);
    checkOutput("clear_fast", {16'd0, led[0]}, 32'h0);
    checkOutput("clear_slow", {16'd0, led[1]}, 32'h0);
    forceOvf = 1'b1;
    busyCount1 = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus((i == 0) || (i == 1) || (i == 3), 1'b0, 16'h0007, 4'b0011);
      waitEdges(1);
      if (busy[1]) busyCount1++;
    end
    forceOvf = 1'b0;
    checkOutput("lat3_busy_cycles", busyCount1, 32'd4);
    checkOutput("lat3_single_op", {16'd0, led[1]}, 32'h7);
    checkOutput("lat3_ovf_set", {31'd0, ovf[1]}, 32'h1);
    checkOutput("fast_untouched", {16'd0, led[0]}, 32'h0);
    waitEdges(8);
    applyStimulus(1'b1, 1'b0, 16'h0001, 4'b0011);
    waitEdges(10);
    applyStimulus(1'b0, 1'b0, 16'h0001, 4'b0011);
    waitEdges(12);
    checkOutput("ovf_sticky", {31'd0, ovf[1]}, 32'h1);
    checkOutput("after_ovf_slow", {16'd0, led[1]}, 32'h8);
    checkOutput("after_ovf_fast", {16'd0, led[0]}, 32'h1);
    checkOutput("no_ovf_fast", {31'd0, ovf[0]}, 32'h0);

    $display("[TB] clear during EXEC");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, i >= 2, 16'h0002, 4'b0010);
      waitEdges(1);
      if (i == 5) begin
        checkOutput("clr_exec_busy", {31'd0, busy[1]}, 32'h0);
        checkOutput("clr_exec_led",  {16'd0, led[1]},  32'h0);
        checkOutput("clr_exec_ovf",  {31'd0, ovf[1]},  32'h0);
      end
      if (i == 8) checkOutput("clr_exec_no_write", {16'd0, led[1]}, 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 16'h0002, 4'b0010);
    waitEdges(12);
    checkOutput("clr_fast_after", {16'd0, led[0]}, 32'h0);

    $display("[TB] coincident clear and execute");
    sawBusy0 = 0; sawBusy1 = 0;
    applyStimulus(1'b1, 1'b1, 16'h0009, 4'b0010);
    for (int i = 0; i < 10; i++) begin
      waitEdges(1);
      if (busy[0]) sawBusy0 = 1;
      if (busy[1]) sawBusy1 = 1;
    end
    applyStimulus(1'b0, 1'b0, 16'h0009, 4'b0010);
    waitEdges(12);
    checkOutput("coinc_no_op_fast", sawBusy0, 32'd0);
    checkOutput("coinc_no_op_slow", sawBusy1, 32'd0);
    checkOutput("coinc_led", {16'd0, led[0]}, 32'h0);

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(1'b1, 1'b0, 16'h0004, 4'b0101);
    waitEdges(10);
    applyStimulus(1'b0, 1'b0, 16'h0004, 4'b0101);
    waitEdges(12);
    checkOutput("pre_rst_led", {16'd0, led[1]}, 32'h4);
    applyStimulus(1'b1, 1'b0, 16'h0004, 4'b0101);
    waitEdges(5);
    checkOutput("pre_rst_busy", {31'd0, busy[1]}, 32'h1);
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_busy",   {31'd0, busy[1]},  32'h0);
    checkOutput("arst_led",    {16'd0, led[1]},   32'h0);
    checkOutput("arst_alu_b",  aluB[1],           32'h0);
    checkOutput("arst_alu_op", {28'd0, aluOp[1]}, 32'h0);
    checkOutput("arst_led_fast", {16'd0, led[0]}, 32'h0);
    waitEdges(2);
    rst = 1'b0;

    $display("[TB] button held through reset");
    sawBusy0 = 0; sawBusy1 = 0;
    for (int i = 0; i < 15; i++) begin
      waitEdges(1);
      if (busy[0]) sawBusy0 = 1;
      if (busy[1]) sawBusy1 = 1;
    end
    checkOutput("held_no_op_fast", sawBusy0, 32'd0);
    checkOutput("held_no_op_slow", sawBusy1, 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0006, 4'b0010);
    waitEdges(10);
    applyStimulus(1'b1, 1'b0, 16'h0006, 4'b0010);
    waitEdges(10);
    applyStimulus(1'b0, 1'b0, 16'h0006, 4'b0010);
    waitEdges(12);
    checkOutput("repress_fast", {16'd0, led[0]}, 32'h6);
    checkOutput("repress_slow", {16'd0, led[1]}, 32'h6);

    printSummary();
    $finish;
  end

  initial begin
    #50000;
    nMismatched++;
    $display("[TB] FAIL watchdog: got timeout, want end of stimulus");
    printSummary();
    $finish;
  end

endmodule
